// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative binary-to-BCD converter.
// Digit correction constants, FSM states and the decimal range helper live here.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int          DIG_W      = 4;
  localparam logic [3:0]  DIG_THRESH = 4'd5;
  localparam logic [3:0]  DIG_ADD    = 4'd3;

  localparam int W_DEF      = 20;
  localparam int DIGITS_DEF = 6;

  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W_DEF = cnt_width(W_DEF);

  // Largest value representable on the display, 10^digits - 1.
  function automatic int unsigned dec_max(input int digits);
    int unsigned p;
    p = 1;
    for (int i = 0; i < digits; i++) p = p * 10;
    return p - 1;
  endfunction

  localparam int unsigned DEC_MAX = dec_max(DIGITS_DEF);

endpackage

// File: rtl/bin2bcd_iter_if.sv
// Conversion request/result bundle between the value source and the converter.
// The display side only consumes dcm/ovf/done; busy is for the requester.
interface bin2bcd_iter_if #(
  parameter int W      = 20,
  parameter int DIGITS = 6
) ();
  logic [W-1:0]          bin;
  logic                  start;
  logic [4*DIGITS-1:0]   dcm;
  logic                  ovf;
  logic                  busy;
  logic                  done;

  modport master (
    output bin, start,
    input  dcm, ovf, busy, done
  );

  modport slave (
    input  bin, start,
    output dcm, ovf, busy, done
  );
endinterface

// File: rtl/bcd_add3.sv
// Single-digit shift-add-3 corrector: digits of 5..9 get +3 before the next shift.
module bcd_add3
  import bin2bcd_pkg::*;
(
  input  logic [3:0] d_in,
  output logic [3:0] d_out
);

  assign d_out = (d_in >= DIG_THRESH) ? (d_in + DIG_ADD) : d_in;

endmodule

// File: rtl/bin2bcd_iter.sv
// Iterative binary-to-BCD converter, one shift per clock, result held until the next conversion completes.
//   state | meaning
//   IDLE  | waiting for start or (AUTO) a new bin value
//   SHIFT | W correction+shift steps, then one cycle to publish the result
//   DONE  | done pulse, dcm/ovf already valid
module bin2bcd_iter
  import bin2bcd_pkg::*;
#(
  parameter int W      = W_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int AUTO   = 1
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_iter_if.slave  bus
);

  // One spare digit so the full W-bit range converts without wrapping.
  localparam int BCD_W = DIG_W * (DIGITS + 1);
  localparam int DCM_W = DIG_W * DIGITS;
  localparam int CNT_W = cnt_width(W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(W);

  state_e           state_q, state_d;
  logic [W-1:0]     shift_q, shift_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     last_bin_q, last_bin_d;
  logic [DCM_W-1:0] dcm_q, dcm_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [BCD_W-1:0] bcd_adj;
  logic             trig;

  for (genvar g = 0; g <= DIGITS; g++) begin : g_dig
    bcd_add3 u_add3 (
      .d_in  (bcd_q[DIG_W*g +: DIG_W]),
      .d_out (bcd_adj[DIG_W*g +: DIG_W])
    );
  end

  assign trig = bus.start | ((AUTO != 0) && (bus.bin != last_bin_q));

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bcd_d      = bcd_q;
    cnt_d      = cnt_q;
    last_bin_d = last_bin_q;
    dcm_d      = dcm_q;
    ovf_d      = ovf_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (trig) begin
          shift_d    = bus.bin;
          last_bin_d = bus.bin;
          bcd_d      = '0;
          cnt_d      = '0;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q == CNT_LAST) begin
          dcm_d   = bcd_q[DCM_W-1:0];
          ovf_d   = |bcd_q[BCD_W-1 -: DIG_W];
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          {bcd_d, shift_d} = {bcd_adj, shift_q} << 1;
          cnt_d            = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bcd_q      <= '0;
      cnt_q      <= '0;
      last_bin_q <= '0;
      dcm_q      <= '0;
      ovf_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bcd_q      <= bcd_d;
      cnt_q      <= cnt_d;
      last_bin_q <= last_bin_d;
      dcm_q      <= dcm_d;
      ovf_q      <= ovf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign bus.dcm  = dcm_q;
  assign bus.ovf  = ovf_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_bin2bcd_iter.sv
// Bench for bin2bcd_iter: one start-only instance and one auto-trigger instance,
// both compared against a decimal-arithmetic reference.
module tb_bin2bcd_iter;
  import bin2bcd_pkg::*;

  localparam int W      = 20;
  localparam int DIGITS = 6;

  logic clk = 1'b0;
  logic rst0, rst1;
  always #5 clk = ~clk;

  bin2bcd_iter_if #(.W(W), .DIGITS(DIGITS)) if0 ();
  bin2bcd_iter_if #(.W(W), .DIGITS(DIGITS)) if1 ();

  bin2bcd_iter #(.W(W), .DIGITS(DIGITS), .AUTO(0)) u_dut0 (
    .clk (clk), .rst (rst0), .bus (if0)
  );
  bin2bcd_iter #(.W(W), .DIGITS(DIGITS), .AUTO(1)) u_dut1 (
    .clk (clk), .rst (rst1), .bus (if1)
  );

  int checks = 0;
  int errors = 0;
  int dones0 = 0;
  int dones1 = 0;
  int convs0 = 0;

  always @(negedge clk) begin
    if (if0.done) dones0++;
    if (if1.done) dones1++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] ref_dcm(input int unsigned v);
    int unsigned m;
    logic [23:0] r;
    m = v % (DEC_MAX + 1);
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(m % 10);
      m = m / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input int unsigned v);
    return v > DEC_MAX;
  endfunction

  // Start-only instance: start sampled at edge 0, result expected at edge 21.
  task automatic conv0(input logic [19:0] v, input bit extra_start, input bit scramble, input bit chk_busy);
    int done_edge;
    int n;
    done_edge = -1;
    n = 0;
    if0.bin   = v;
    if0.start = 1'b1;
    @(posedge clk); #1;
    if0.start = 1'b0;
    convs0++;
    for (int e = 1; e <= 30; e++) begin
      if (extra_start && e == 5) if0.start = 1'b1;
      if (extra_start && e == 6) if0.start = 1'b0;
      if (scramble && e == 8) if0.bin = 20'($urandom);
      @(posedge clk); #1;
      if (if0.done) begin
        n++;
        if (done_edge < 0) done_edge = e;
      end
      if (chk_busy && (e == 1 || e == 21)) chk("busy_high", 64'(if0.busy), 64'd1);
      if (chk_busy && e == 22) chk("busy_low", 64'(if0.busy), 64'd0);
    end
    chk("done_edge", 64'(done_edge), 64'd21);
    chk("done_pulses", 64'(n), 64'd1);
    chk("dcm", 64'(if0.dcm), 64'(ref_dcm(32'(v))));
    chk("ovf", 64'(if0.ovf), 64'(ref_ovf(32'(v))));
  endtask

  // Auto instance: new bin (and optional start) sampled at the next edge, counted as edge 0.
  task automatic auto_wait(input logic [19:0] v, input bit with_start);
    int done_edge;
    int n;
    done_edge = -1;
    n = 0;
    if1.bin   = v;
    if1.start = with_start;
    for (int e = 0; e <= 30; e++) begin
      @(posedge clk); #1;
      if1.start = 1'b0;
      if (if1.done) begin
        n++;
        if (done_edge < 0) done_edge = e;
      end
    end
    chk("auto_done_edge", 64'(done_edge), 64'd21);
    chk("auto_done_pulses", 64'(n), 64'd1);
    chk("auto_dcm", 64'(if1.dcm), 64'(ref_dcm(32'(v))));
    chk("auto_ovf", 64'(if1.ovf), 64'(ref_ovf(32'(v))));
  endtask

  task automatic auto_static(input string tag);
    int n;
    n = dones1;
    repeat (30) @(posedge clk);
    #1;
    chk(tag, 64'(dones1 - n), 64'd0);
  endtask

  initial begin
    rst0 = 1'b1;
    rst1 = 1'b1;
    if0.bin = '0; if0.start = 1'b0;
    if1.bin = '0; if1.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dcm", 64'(if0.dcm), 64'd0);
    chk("rst_ovf", 64'(if0.ovf), 64'd0);
    chk("rst_busy", 64'(if0.busy), 64'd0);
    chk("rst_done", 64'(if0.done), 64'd0);
    rst0 = 1'b0;
    rst1 = 1'b0;

    conv0(20'd0, 1'b0, 1'b0, 1'b1);
    conv0(20'd123456, 1'b1, 1'b0, 1'b1);
    conv0(20'd999999, 1'b0, 1'b0, 1'b0);
    conv0(20'd1048575, 1'b0, 1'b0, 1'b0);
    conv0(20'd1000000, 1'b0, 1'b0, 1'b0);

    auto_static("auto_zero_static");
    auto_wait(20'd7, 1'b0);
    auto_static("auto_seven_static");
    auto_wait(20'd65535, 1'b0);
    auto_wait(20'd999999, 1'b1);

    // Reset in the middle of a conversion must clear the held result at once.
    if1.bin = 20'd654321;
    repeat (11) @(posedge clk);
    #1;
    rst1 = 1'b1;
    #1;
    chk("midrst_dcm", 64'(if1.dcm), 64'd0);
    chk("midrst_ovf", 64'(if1.ovf), 64'd0);
    chk("midrst_busy", 64'(if1.busy), 64'd0);
    chk("midrst_done", 64'(if1.done), 64'd0);
    @(posedge clk); #1;
    rst1 = 1'b0;
    auto_wait(20'd654321, 1'b0);

    for (int i = 0; i < 500; i++) begin
      conv0(20'($urandom_range(0, (1 << W) - 1)), 1'b0, 1'b1, 1'b0);
    end
    chk("done_total", 64'(dones0), 64'(convs0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
